ibex_rf_wb_arbiter: RTL and testbench

Write-port arbiter and read bypass for the single-write-port integer register file. Shares the register file write port between the execute-stage writeback (EX) and the load/store-unit writeback (LSU) using round-robin arbitration with valid/ready handshakes. Suppresses writes to x0 and counts arbitration conflicts. Sits between the writeback sources and the register file, with the read data returned to the decoder passing through it.

---
 rtl/ibex_rf_wb_arbiter_if.sv | 40 ++++
 rtl/ibex_rf_wb_arbiter.sv | 108 ++++++++++
 tb/tb_ibex_rf_wb_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ibex_rf_wb_arbiter_if.sv
// Writeback arbiter bundle: EX/LSU write requests, register file write port,
// read bypass path and conflict count.
interface ibex_rf_wb_arbiter_if #(
  parameter int unsigned DataWidth = 32
);
  logic                 ex_valid_i;
  logic                 ex_ready_o;
  logic [4:0]           ex_waddr_i;
  logic [DataWidth-1:0] ex_wdata_i;
  logic                 lsu_valid_i;
  logic                 lsu_ready_o;
  logic [4:0]           lsu_waddr_i;
  logic [DataWidth-1:0] lsu_wdata_i;
  logic                 rf_we_o;
  logic [4:0]           rf_waddr_o;
  logic [DataWidth-1:0] rf_wdata_o;
  logic [4:0]           raddr_a_i;
  logic [4:0]           raddr_b_i;
  logic [DataWidth-1:0] rf_rdata_a_i;
  logic [DataWidth-1:0] rf_rdata_b_i;
  logic [DataWidth-1:0] rdata_a_o;
  logic [DataWidth-1:0] rdata_b_o;
  logic [15:0]          conflict_cnt_o;

  modport slave (
    input  ex_valid_i, ex_waddr_i, ex_wdata_i,
    input  lsu_valid_i, lsu_waddr_i, lsu_wdata_i,
    input  raddr_a_i, raddr_b_i, rf_rdata_a_i, rf_rdata_b_i,
    output ex_ready_o, lsu_ready_o, rf_we_o, rf_waddr_o, rf_wdata_o,
    output rdata_a_o, rdata_b_o, conflict_cnt_o
  );

  modport master (
    output ex_valid_i, ex_waddr_i, ex_wdata_i,
    output lsu_valid_i, lsu_waddr_i, lsu_wdata_i,
    output raddr_a_i, raddr_b_i, rf_rdata_a_i, rf_rdata_b_i,
    input  ex_ready_o, lsu_ready_o, rf_we_o, rf_waddr_o, rf_wdata_o,
    input  rdata_a_o, rdata_b_o, conflict_cnt_o
  );
endinterface

// File: rtl/ibex_rf_wb_arbiter.sv
// Round-robin EX/LSU arbiter for the register file write port with x0 drop,
// conflict counter and optional one-cycle read bypass (IBEX_RF_WB_BYPASS_EN).
module ibex_rf_wb_arbiter #(
  parameter bit          RV32E     = 1'b0,
  parameter int unsigned DataWidth = 32
) (
  input logic                 clk_i,
  input logic                 rst_ni,
  ibex_rf_wb_arbiter_if.slave wb
);
  localparam int unsigned AddrWidth = 5;
  localparam int unsigned CntWidth  = 16;
  localparam logic [0:0]  PrioEx    = 1'b0;
  localparam logic [0:0]  PrioLsu   = 1'b1;

  logic [0:0]           prio_q, prio_d;
  logic [CntWidth-1:0]  conflict_q, conflict_d;
  logic                 conflict, ex_gnt, lsu_gnt, rf_we;
  logic [AddrWidth-1:0] waddr;
  logic [DataWidth-1:0] wdata;

  // RV32E only decodes x0..x15.
  function automatic logic [AddrWidth-1:0] mask_addr(input logic [AddrWidth-1:0] a);
    return RV32E ? {1'b0, a[3:0]} : a;
  endfunction

  // Grant, write mux and next-state logic.
  always_comb begin
    conflict   = wb.ex_valid_i & wb.lsu_valid_i;
    ex_gnt     = wb.ex_valid_i & (~wb.lsu_valid_i | (prio_q == PrioEx));
    lsu_gnt    = wb.lsu_valid_i & (~wb.ex_valid_i | (prio_q == PrioLsu));
    waddr      = '0;
    wdata      = '0;
    prio_d     = prio_q;
    conflict_d = conflict_q;
    if (ex_gnt) begin
      waddr  = mask_addr(wb.ex_waddr_i);
      wdata  = wb.ex_wdata_i;
      prio_d = PrioLsu;
    end else if (lsu_gnt) begin
      waddr  = mask_addr(wb.lsu_waddr_i);
      wdata  = wb.lsu_wdata_i;
      prio_d = PrioEx;
    end
    rf_we = (ex_gnt | lsu_gnt) & (waddr != '0);
    if (conflict && (conflict_q != {CntWidth{1'b1}})) begin
      conflict_d = conflict_q + CntWidth'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prio_q     <= PrioEx;
      conflict_q <= '0;
    end else begin
      prio_q     <= prio_d;
      conflict_q <= conflict_d;
    end
  end

  assign wb.ex_ready_o     = ex_gnt;
  assign wb.lsu_ready_o    = lsu_gnt;
  assign wb.rf_we_o        = rf_we;
  assign wb.rf_waddr_o     = waddr;
  assign wb.rf_wdata_o     = wdata;
  assign wb.conflict_cnt_o = conflict_q;

`ifdef IBEX_RF_WB_BYPASS_EN
  logic                 byp_vld_q, byp_vld_d;
  logic [AddrWidth-1:0] byp_addr_q, byp_addr_d;
  logic [DataWidth-1:0] byp_data_q, byp_data_d;

  // Hold the last written value for exactly one cycle.
  always_comb begin
    byp_vld_d  = rf_we;
    byp_addr_d = byp_addr_q;
    byp_data_d = byp_data_q;
    if (rf_we) begin
      byp_addr_d = waddr;
      byp_data_d = wdata;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      byp_vld_q  <= 1'b0;
      byp_addr_q <= '0;
      byp_data_q <= '0;
    end else begin
      byp_vld_q  <= byp_vld_d;
      byp_addr_q <= byp_addr_d;
      byp_data_q <= byp_data_d;
    end
  end

  assign wb.rdata_a_o = (byp_vld_q && (mask_addr(wb.raddr_a_i) == byp_addr_q)) ?
                        byp_data_q : wb.rf_rdata_a_i;
  assign wb.rdata_b_o = (byp_vld_q && (mask_addr(wb.raddr_b_i) == byp_addr_q)) ?
                        byp_data_q : wb.rf_rdata_b_i;
`else
  // Read addresses only feed the register file itself in this build.
  logic unused_raddr;
  assign unused_raddr = ^{wb.raddr_a_i, wb.raddr_b_i};
  assign wb.rdata_a_o = wb.rf_rdata_a_i;
  assign wb.rdata_b_o = wb.rf_rdata_b_i;
`endif

endmodule

// File: tb/tb_ibex_rf_wb_arbiter.sv
// Self-checking bench for ibex_rf_wb_arbiter: RV32I and RV32E instances share
// stimulus and are checked against a transaction-level reference model.
module tb_ibex_rf_wb_arbiter;
  localparam int unsigned DW = 32;

  logic clk_i = 1'b0;
  logic rst_ni;
  always #5 clk_i = ~clk_i;

  logic          ex_valid, lsu_valid;
  logic [4:0]    ex_waddr, lsu_waddr, raddr_a, raddr_b;
  logic [DW-1:0] ex_wdata, lsu_wdata, rf_rdata_a, rf_rdata_b;

  ibex_rf_wb_arbiter_if #(.DataWidth(DW)) bus0 ();
  ibex_rf_wb_arbiter_if #(.DataWidth(DW)) bus1 ();

  assign bus0.ex_valid_i = ex_valid;     assign bus1.ex_valid_i = ex_valid;
  assign bus0.ex_waddr_i = ex_waddr;     assign bus1.ex_waddr_i = ex_waddr;
  assign bus0.ex_wdata_i = ex_wdata;     assign bus1.ex_wdata_i = ex_wdata;
  assign bus0.lsu_valid_i = lsu_valid;   assign bus1.lsu_valid_i = lsu_valid;
  assign bus0.lsu_waddr_i = lsu_waddr;   assign bus1.lsu_waddr_i = lsu_waddr;
  assign bus0.lsu_wdata_i = lsu_wdata;   assign bus1.lsu_wdata_i = lsu_wdata;
  assign bus0.raddr_a_i = raddr_a;       assign bus1.raddr_a_i = raddr_a;
  assign bus0.raddr_b_i = raddr_b;       assign bus1.raddr_b_i = raddr_b;
  assign bus0.rf_rdata_a_i = rf_rdata_a; assign bus1.rf_rdata_a_i = rf_rdata_a;
  assign bus0.rf_rdata_b_i = rf_rdata_b; assign bus1.rf_rdata_b_i = rf_rdata_b;

  ibex_rf_wb_arbiter #(.RV32E(1'b0), .DataWidth(DW)) u_dut (
    .clk_i (clk_i), .rst_ni(rst_ni), .wb(bus0));
  ibex_rf_wb_arbiter #(.RV32E(1'b1), .DataWidth(DW)) u_dut_e (
    .clk_i (clk_i), .rst_ni(rst_ni), .wb(bus1));

  int checks = 0;
  int failures = 0;

  // Reference model: grant history, conflict tally, last write per instance.
  bit          glog[$];
  int unsigned conflicts;
  int          cyc;
  int          wr_cyc[2];
  logic [4:0]  wr_addr[2];
  logic [31:0] wr_data[2];
  logic        last_eg, last_lg;
  logic [4:0]  last_ga;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] msk(input int inst, input logic [4:0] a);
    logic [4:0] m;
    m = a;
    if (inst == 1) m[4] = 1'b0;
    return m;
  endfunction

  // EX is favoured unless the most recent grant went to EX.
  function automatic bit favour_lsu();
    return (glog.size() > 0) && (glog[glog.size()-1] == 1'b0);
  endfunction

  function automatic logic gnt_ex();
    return ex_valid && (!lsu_valid || !favour_lsu());
  endfunction

  function automatic logic gnt_lsu();
    return lsu_valid && !gnt_ex();
  endfunction

  function automatic logic [31:0] exp_rd(input int inst, input logic [4:0] ra,
                                         input logic [31:0] raw);
    bit use_byp;
`ifdef IBEX_RF_WB_BYPASS_EN
    use_byp = 1'b1;
`else
    use_byp = 1'b0;
`endif
    if (use_byp && (wr_cyc[inst] == cyc - 1) && (msk(inst, ra) == wr_addr[inst]))
      return wr_data[inst];
    return raw;
  endfunction

  task automatic model_clear();
    glog.delete();
    conflicts = 0;
    cyc = 0;
    for (int i = 0; i < 2; i++) begin
      wr_cyc[i] = -10; wr_addr[i] = '0; wr_data[i] = '0;
    end
    last_eg = 1'b0; last_lg = 1'b0; last_ga = '0;
  endtask

  task automatic model_update();
    logic eg, lg;
    logic [4:0] ga, a;
    logic [31:0] gd;
    eg = gnt_ex();
    lg = gnt_lsu();
    ga = eg ? ex_waddr : (lg ? lsu_waddr : 5'd0);
    gd = eg ? ex_wdata : (lg ? lsu_wdata : 32'd0);
    if (ex_valid && lsu_valid) conflicts++;
    if (eg) glog.push_back(1'b0);
    else if (lg) glog.push_back(1'b1);
    if (glog.size() > 8) void'(glog.pop_front());
    for (int i = 0; i < 2; i++) begin
      a = msk(i, ga);
      if ((eg || lg) && (a != 5'd0)) begin
        wr_cyc[i] = cyc; wr_addr[i] = a; wr_data[i] = gd;
      end
    end
    cyc++;
    last_eg = eg; last_lg = lg;
    if (eg || lg) last_ga = ga;
  endtask

  task automatic check_inst(input int inst, input logic exr, input logic lsr,
                            input logic we, input logic [4:0] wa, input logic [31:0] wd,
                            input logic [31:0] ra, input logic [31:0] rb,
                            input logic [15:0] cnt);
    logic eg, lg;
    logic [4:0] ga;
    logic [31:0] gd;
    eg = gnt_ex();
    lg = gnt_lsu();
    ga = msk(inst, eg ? ex_waddr : (lg ? lsu_waddr : 5'd0));
    gd = eg ? ex_wdata : (lg ? lsu_wdata : 32'd0);
    chk($sformatf("i%0d_ex_ready", inst), 32'(exr), 32'(eg));
    chk($sformatf("i%0d_lsu_ready", inst), 32'(lsr), 32'(lg));
    chk($sformatf("i%0d_rf_we", inst), 32'(we), 32'((eg || lg) && (ga != 5'd0)));
    chk($sformatf("i%0d_rf_waddr", inst), 32'(wa), 32'(ga));
    chk($sformatf("i%0d_rf_wdata", inst), wd, gd);
    chk($sformatf("i%0d_rdata_a", inst), ra, exp_rd(inst, raddr_a, rf_rdata_a));
    chk($sformatf("i%0d_rdata_b", inst), rb, exp_rd(inst, raddr_b, rf_rdata_b));
    chk($sformatf("i%0d_conflict_cnt", inst), 32'(cnt),
        (conflicts > 65535) ? 32'd65535 : 32'(conflicts));
  endtask

  task automatic check_now();
    check_inst(0, bus0.ex_ready_o, bus0.lsu_ready_o, bus0.rf_we_o, bus0.rf_waddr_o,
               bus0.rf_wdata_o, bus0.rdata_a_o, bus0.rdata_b_o, bus0.conflict_cnt_o);
    check_inst(1, bus1.ex_ready_o, bus1.lsu_ready_o, bus1.rf_we_o, bus1.rf_waddr_o,
               bus1.rf_wdata_o, bus1.rdata_a_o, bus1.rdata_b_o, bus1.conflict_cnt_o);
  endtask

  // Check mid-cycle, then let the edge complete and advance the model.
  task automatic step();
    #2;
    check_now();
    @(posedge clk_i);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    ex_valid = 1'b0; lsu_valid = 1'b0;
    rst_ni = 1'b0;
    model_clear();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    ex_valid = 1'b0; lsu_valid = 1'b0;
    ex_waddr = '0; lsu_waddr = '0; ex_wdata = '0; lsu_wdata = '0;
    raddr_a = '0; raddr_b = '0; rf_rdata_a = 32'h0101_0101; rf_rdata_b = 32'h0202_0202;
    do_reset();
    step();

    // Single source
    ex_valid = 1'b1; ex_waddr = 5'd5; ex_wdata = 32'hDEAD_BEEF;
    #1;
    chk("single_ex_ready", 32'(bus0.ex_ready_o), 32'd1);
    chk("single_waddr", 32'(bus0.rf_waddr_o), 32'd5);
    chk("single_wdata", bus0.rf_wdata_o, 32'hDEAD_BEEF);
    step();
    ex_valid = 1'b0;
    step();

    // Round-robin: held loser, winner re-asserts a fresh request
    do_reset();
    ex_valid = 1'b1; ex_waddr = 5'd1; ex_wdata = 32'h11;
    lsu_valid = 1'b1; lsu_waddr = 5'd2; lsu_wdata = 32'h22;
    #1; chk("rr0_ex", 32'(bus0.ex_ready_o), 32'd1);
    step();
    ex_waddr = 5'd3; ex_wdata = 32'h33;
    #1; chk("rr1_lsu", 32'(bus0.lsu_ready_o), 32'd1);
    step();
    lsu_waddr = 5'd4; lsu_wdata = 32'h44;
    #1; chk("rr2_ex", 32'(bus0.ex_ready_o), 32'd1);
    step();
    ex_waddr = 5'd6; ex_wdata = 32'h66;
    #1; chk("rr3_lsu", 32'(bus0.lsu_ready_o), 32'd1);
    step();
    ex_valid = 1'b0; lsu_valid = 1'b0;
    #1; chk("rr_conflicts", 32'(bus0.conflict_cnt_o), 32'd4);
    step();

    // x0 drop
    lsu_valid = 1'b1; lsu_waddr = 5'd0; lsu_wdata = 32'h1234;
    step();
    lsu_valid = 1'b0; raddr_a = 5'd0; rf_rdata_a = 32'h55;
    #1; chk("x0_no_bypass", bus0.rdata_a_o, 32'h55);
    step();

    // Bypass hit then expiry
    ex_valid = 1'b1; ex_waddr = 5'd7; ex_wdata = 32'hA5A5_A5A5;
    step();
    ex_valid = 1'b0; raddr_a = 5'd7; rf_rdata_a = 32'h0;
    step();
    rf_rdata_a = 32'h1111;
    #1; chk("byp_expired", bus0.rdata_a_o, 32'h1111);
    step();

    // RV32E masking, and 5'h10 aliasing x0 only on RV32E
    ex_valid = 1'b1; ex_waddr = 5'h13; ex_wdata = 32'h77;
    #1; chk("rv32e_waddr", 32'(bus1.rf_waddr_o), 32'h03);
    step();
    ex_valid = 1'b0; raddr_b = 5'h03; rf_rdata_b = 32'h99;
    step();
    ex_valid = 1'b1; ex_waddr = 5'h10; ex_wdata = 32'h88;
    #1; chk("rv32e_x0_alias_we", 32'(bus1.rf_we_o), 32'd0);
    step();
    ex_valid = 1'b0; raddr_a = 5'h10; raddr_b = 5'h00;
    step();

    // Back-to-back writes to one register; same-cycle read sees older value
    ex_valid = 1'b1; ex_waddr = 5'd9; ex_wdata = 32'h1;
    step();
    ex_wdata = 32'h2; raddr_a = 5'd9; rf_rdata_a = 32'hF0;
    step();
    ex_valid = 1'b0;
    step();

    // Async reset with a pending conflict while LSU is favoured
    do_reset();
    ex_valid = 1'b1; ex_waddr = 5'd7; ex_wdata = 32'hCAFE;
    step();
    lsu_valid = 1'b1; lsu_waddr = 5'd8; lsu_wdata = 32'hBEE;
    ex_waddr = 5'd9; ex_wdata = 32'hF00D; raddr_a = 5'd7; rf_rdata_a = 32'h0BAD;
    #2; check_now();
    #1; rst_ni = 1'b0;
    #1;
    chk("rst_cnt", 32'(bus0.conflict_cnt_o), 32'd0);
    chk("rst_byp", bus0.rdata_a_o, 32'h0BAD);
    chk("rst_prio", 32'(bus0.ex_ready_o), 32'd1);
    ex_valid = 1'b0; lsu_valid = 1'b0;
    model_clear();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i); rst_ni = 1'b1;
    @(posedge clk_i); #1;
    ex_valid = 1'b1; lsu_valid = 1'b1;
    #1; chk("post_rst_ex_first", 32'(bus0.ex_ready_o), 32'd1);
    step();
    ex_valid = 1'b0; lsu_valid = 1'b0;
    step();

    // Randomized traffic obeying the hold-until-granted rule
    for (int i = 0; i < 400; i++) begin
      if (!ex_valid || last_eg) begin
        ex_valid = ($urandom_range(0, 9) < 6);
        ex_waddr = 5'($urandom_range(0, 31));
        ex_wdata = $urandom;
      end
      if (!lsu_valid || last_lg) begin
        lsu_valid = ($urandom_range(0, 9) < 6);
        lsu_waddr = 5'($urandom_range(0, 31));
        lsu_wdata = $urandom;
      end
      raddr_a = ($urandom_range(0, 2) == 0) ? 5'($urandom_range(0, 31))
                                            : (last_ga ^ {$urandom_range(0, 1) == 1, 4'b0});
      raddr_b = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 31)) : last_ga;
      rf_rdata_a = $urandom;
      rf_rdata_b = $urandom;
      step();
    end

    // Conflict counter saturation
    do_reset();
    ex_valid = 1'b1; ex_waddr = 5'd1; ex_wdata = 32'h1;
    lsu_valid = 1'b1; lsu_waddr = 5'd2; lsu_wdata = 32'h2;
    for (int i = 0; i < 65530; i++) begin
      @(posedge clk_i);
      model_update();
      #1;
    end
    for (int i = 0; i < 8; i++) step();
    #1; chk("cnt_saturated", 32'(bus0.conflict_cnt_o), 32'h0000_FFFF);
    ex_valid = 1'b0; lsu_valid = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
